// File: rtl/hall_input_monitor.sv
// Hall-sensor front end for one motor: synchronize, debounce, classify connection
// state, and track step count, direction and step period for the commutation stage.
module hall_input_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8,
    parameter int PERIOD_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hall_a,
    input  logic                    hall_b,
    input  logic                    hall_c,
    input  logic                    count_load,
    input  logic [COUNT_WIDTH-1:0]  count_load_value,
    output logic [2:0]              hall_state,
    output logic                    connected,
    output logic                    fault,
    output logic [COUNT_WIDTH-1:0]  hall_count,
    output logic                    direction,
    output logic                    step_pulse,
    output logic                    step_error,
    output logic [PERIOD_WIDTH-1:0] step_period
);

    localparam int STB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STB_W-1:0]        STB_MAX = STB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STB_W-1:0]        STB_ONE = STB_W'(1);
    localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [2:0]              H_OPEN  = 3'b111;
    localparam logic [2:0]              H_SHORT = 3'b000;

    typedef enum logic [1:0] {
        ST_DISC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  sync_val;
    logic [2:0]                  cand_q, cand_d;
    logic [STB_W-1:0]            stable_q, stable_d;
    logic                        filt_upd;
    logic [2:0]                  new_pos, cur_pos;
    logic                        step_fwd, step_rev, jump, step;
    logic [PERIOD_WIDTH-1:0]     per_cnt;

    // Position around the six-state forward cycle; 7 marks an invalid code.
    function automatic logic [2:0] hall_pos(input logic [2:0] h);
        case (h)
            3'b101:  hall_pos = 3'd0;
            3'b100:  hall_pos = 3'd1;
            3'b110:  hall_pos = 3'd2;
            3'b010:  hall_pos = 3'd3;
            3'b011:  hall_pos = 3'd4;
            3'b001:  hall_pos = 3'd5;
            default: hall_pos = 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] pos_inc(input logic [2:0] p);
        return (p == 3'd5) ? 3'd0 : p + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{H_OPEN}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], hall_a, hall_b, hall_c};
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // The sample that loads the candidate counts as the first stable one, so the
    // filtered value moves on the same edge the count reaches its limit.
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        if (sync_val != cand_q) begin
            cand_d   = sync_val;
            stable_d = '0;
        end else if (stable_q != STB_MAX) begin
            stable_d = stable_q + STB_ONE;
        end
    end

    assign filt_upd = (stable_d == STB_MAX) && (cand_d != hall_state);
    assign new_pos  = hall_pos(cand_d);
    assign cur_pos  = hall_pos(hall_state);

    always_comb begin
        state_d  = state_q;
        step_fwd = 1'b0;
        step_rev = 1'b0;
        jump     = 1'b0;
        if (filt_upd) begin
            case (state_q)
                ST_DISC: begin
                    if (cand_d == H_SHORT)     state_d = ST_FAULT;
                    else if (new_pos != 3'd7)  state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cand_d == H_OPEN)                  state_d  = ST_DISC;
                    else if (cand_d == H_SHORT)            state_d  = ST_FAULT;
                    else if (new_pos == pos_inc(cur_pos))  step_fwd = 1'b1;
                    else if (cur_pos == pos_inc(new_pos))  step_rev = 1'b1;
                    else                                   jump     = 1'b1;
                end
                ST_FAULT: begin
                    if (cand_d == H_OPEN) state_d = ST_DISC;
                end
                default: state_d = ST_DISC;
            endcase
        end
    end

    assign step = step_fwd | step_rev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DISC;
            cand_q      <= H_OPEN;
            stable_q    <= '0;
            hall_state  <= H_OPEN;
            hall_count  <= '0;
            direction   <= 1'b0;
            step_pulse  <= 1'b0;
            step_error  <= 1'b0;
            step_period <= '0;
            per_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            step_pulse <= step;
            step_error <= jump;
            if (filt_upd) hall_state <= cand_d;
            // An SPI load overrides a same-cycle step's count change.
            if (count_load)    hall_count <= count_load_value;
            else if (step_fwd) hall_count <= hall_count + CNT_ONE;
            else if (step_rev) hall_count <= hall_count - CNT_ONE;
            if (step) direction <= step_fwd;
            // The step edge itself is the first cycle of the next period.
            if (state_d != ST_RUN) begin
                per_cnt     <= '0;
                step_period <= '0;
            end else if (step) begin
                per_cnt     <= PER_ONE;
                step_period <= per_cnt;
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + PER_ONE;
            end
        end
    end

    assign connected = (state_q == ST_RUN);
    assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_hall_input_monitor.sv
// Bench for hall_input_monitor: step pulses/errors are checked against a queue of
// expected results pushed when each hall transition is driven.
module tb_hall_input_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hall_a, hall_b, hall_c;
    logic        count_load;
    logic [7:0]  count_load_value;
    logic [2:0]  hall_state;
    logic        connected, fault;
    logic [7:0]  hall_count;
    logic        direction, step_pulse, step_error;
    logic [15:0] step_period;

    typedef struct {
        logic        err;
        logic [7:0]  count;
        logic        dir;
        logic [15:0] period;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;

    hall_input_monitor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hall_a           (hall_a),
        .hall_b           (hall_b),
        .hall_c           (hall_c),
        .count_load       (count_load),
        .count_load_value (count_load_value),
        .hall_state       (hall_state),
        .connected        (connected),
        .fault            (fault),
        .hall_count       (hall_count),
        .direction        (direction),
        .step_pulse       (step_pulse),
        .step_error       (step_error),
        .step_period      (step_period)
    );

    always #5 clk = ~clk;

    // Scoreboard: every step/error pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && (step_pulse || step_error)) begin
            n_checks++;
            n_pulses++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: step_pulse=%0b step_error=%0b count=%h", step_pulse, step_error, hall_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({step_pulse, step_error, hall_count, direction, step_period} !== {~e.err, e.err, e.count, e.dir, e.period}) begin
                    n_fail++;
                    $display("FAIL sb_step: got pulse=%0b err=%0b count=%h dir=%0b period=%h, want pulse=%0b err=%0b count=%h dir=%0b period=%h",
                             step_pulse, step_error, hall_count, direction, step_period, ~e.err, e.err, e.count, e.dir, e.period);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] h);
        {hall_a, hall_b, hall_c} = h;
    endtask

    task automatic do_step(input logic [2:0] h, input logic err, input logic [7:0] c,
                           input logic d, input logic [15:0] p, input int gap);
        exp_t e;
        e.err = err; e.count = c; e.dir = d; e.period = p;
        sb.push_back(e);
        drive(h);
        cyc(gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(3'b111);
        count_load = 1'b0;
        count_load_value = 8'h00;
        cyc(2);
        #1;
        n_checks++;
        if ({hall_state, connected, fault, hall_count, step_pulse} !== {3'b111, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: state=%b conn=%0b fault=%0b count=%h", hall_state, connected, fault, hall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(100);
        n_checks++;
        if ({hall_state, connected, fault, hall_count, direction, step_period} !== {3'b111, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_idle: state=%b conn=%0b fault=%0b count=%h dir=%0b period=%h",
                     hall_state, connected, fault, hall_count, direction, step_period);
        end
    endtask

    task automatic test_fault;
        drive(3'b000);
        cyc(5);
        n_checks++;
        if (fault !== 1'b0 || hall_state !== 3'b111) begin
            n_fail++;
            $display("FAIL fault_early: fault=%0b state=%b want 0/111", fault, hall_state);
        end
        cyc(1);
        n_checks++;
        if (fault !== 1'b1 || hall_state !== 3'b000) begin
            n_fail++;
            $display("FAIL fault_latency: fault=%0b state=%b want 1/000", fault, hall_state);
        end
        cyc(14);
        drive(3'b101);
        cyc(10);
        n_checks++;
        if (fault !== 1'b1 || connected !== 1'b0 || hall_state !== 3'b101) begin
            n_fail++;
            $display("FAIL fault_latched: fault=%0b conn=%0b state=%b", fault, connected, hall_state);
        end
        drive(3'b111);
        cyc(10);
        n_checks++;
        if (fault !== 1'b0 || connected !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%0b conn=%0b want 0/0", fault, connected);
        end
        drive(3'b101);
        cyc(10);
        n_checks++;
        if (connected !== 1'b1 || hall_count !== 8'h00 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL connect: conn=%0b count=%h fault=%0b want 1/00/0", connected, hall_count, fault);
        end
    endtask

    // Running at 101, entered 4 edges before the first step is driven.
    task automatic test_steps;
        int p0;
        p0 = n_pulses;
        do_step(3'b100, 1'b0, 8'd1, 1'b1, 16'd10, 50);
        do_step(3'b110, 1'b0, 8'd2, 1'b1, 16'd50, 50);
        do_step(3'b010, 1'b0, 8'd3, 1'b1, 16'd50, 50);
        do_step(3'b110, 1'b0, 8'd2, 1'b0, 16'd50, 50);
        n_checks++;
        if (hall_count !== 8'd2 || direction !== 1'b0 || step_period !== 16'd50) begin
            n_fail++;
            $display("FAIL steps_final: count=%h dir=%0b period=%0d want 02/0/50", hall_count, direction, step_period);
        end
        n_checks++;
        if (n_pulses - p0 != 4 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL steps_pulses: pulses=%0d pending=%0d want 4/0", n_pulses - p0, sb.size());
        end
    endtask

    task automatic test_count_load;
        count_load = 1'b1; count_load_value = 8'hFF;
        cyc(1);
        count_load = 1'b0;
        n_checks++;
        if (hall_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL load_ff: count=%h want ff", hall_count);
        end
        do_step(3'b010, 1'b0, 8'h00, 1'b1, 16'd51, 50);
        count_load = 1'b1; count_load_value = 8'h00;
        cyc(1);
        count_load = 1'b0;
        n_checks++;
        if (hall_count !== 8'h00) begin
            n_fail++;
            $display("FAIL load_00: count=%h want 00", hall_count);
        end
        do_step(3'b110, 1'b0, 8'hFF, 1'b0, 16'd51, 50);
        // Load lands on the same edge as the filtered 110 -> 010 update.
        do_step(3'b010, 1'b0, 8'h0A, 1'b1, 16'd50, 5);
        count_load = 1'b1; count_load_value = 8'h0A;
        cyc(1);
        count_load = 1'b0;
        cyc(44);
        n_checks++;
        if (hall_count !== 8'h0A || direction !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL load_coincident: count=%h dir=%0b pending=%0d want 0a/1/0", hall_count, direction, sb.size());
        end
    endtask

    task automatic test_glitch_jump;
        bit moved = 0;
        drive(3'b011);
        cyc(3);
        drive(3'b010);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (hall_state !== 3'b010) moved = 1;
        end
        n_checks++;
        if (moved || hall_count !== 8'h0A) begin
            n_fail++;
            $display("FAIL glitch: moved=%0b count=%h want 0/0a", moved, hall_count);
        end
        do_step(3'b101, 1'b1, 8'h0A, 1'b1, 16'd50, 50);
        n_checks++;
        if (hall_state !== 3'b101 || connected !== 1'b1 || step_error !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL jump: state=%b conn=%0b err=%0b pending=%0d want 101/1/0/0", hall_state, connected, step_error, sb.size());
        end
    endtask

    task automatic test_period_saturate;
        cyc(70000);
        do_step(3'b100, 1'b0, 8'h0B, 1'b1, 16'hFFFF, 20);
        n_checks++;
        if (step_period !== 16'hFFFF || sb.size() != 0) begin
            n_fail++;
            $display("FAIL period_sat: period=%h pending=%0d want ffff/0", step_period, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        drive(3'b110);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hall_state, connected, fault, hall_count, direction, step_pulse, step_error, step_period}
            !== {3'b111, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: state=%b conn=%0b fault=%0b count=%h dir=%0b period=%h",
                     hall_state, connected, fault, hall_count, direction, step_period);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);
        n_checks++;
        if (hall_state !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_relatch_early: state=%b want 111", hall_state);
        end
        cyc(1);
        n_checks++;
        if (hall_state !== 3'b110 || connected !== 1'b1 || hall_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_relatch: state=%b conn=%0b count=%h want 110/1/00", hall_state, connected, hall_count);
        end
        cyc(5);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending=%0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fault();
        test_steps();
        test_count_load();
        test_glitch_jump();
        test_period_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hall_input_monitor.md
Name: hall_input_monitor

Overview:
- Per-motor hall-sensor front end. Sits directly upstream of the BLDC commutation and duty-cycle stage, and feeds the hall-count register that the SPI slave reads with command 0x92 and writes with command 0x12.
- Synchronizes and debounces raw hall_a/b/c, then classifies the motor as disconnected, running or faulted.
- Maintains a signed-wrapping hall step count, direction flag and step period for speed estimation.
- The top level instantiates one copy per motor (NUM_MOTORS copies).

Parameters:
- SYNC_STAGES, 2, flip-flop synchronizer depth on each hall input (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required before the filtered state updates (minimum 1).
- COUNT_WIDTH, 8, width of the hall step counter.
- PERIOD_WIDTH, 16, width of the step-period counter (saturating).

Ports:
- clk  in  1  system clock (sysclk at top level).
- rst_n  in  1  asynchronous active-low reset.
- hall_a  in  1  raw hall input A, asynchronous to clk.
- hall_b  in  1  raw hall input B.
- hall_c  in  1  raw hall input C.
- count_load  in  1  one-cycle strobe from the SPI 0x12 write path.
- count_load_value  in  COUNT_WIDTH  value to load into hall_count.
- hall_state  out  3  filtered {a,b,c}.
- connected  out  1  high while in RUNNING.
- fault  out  1  high while in FAULT.
- hall_count  out  COUNT_WIDTH  wrapping step count.
- direction  out  1  1 = last valid step was forward, 0 = reverse.
- step_pulse  out  1  one-cycle pulse on each valid adjacent step.
- step_error  out  1  one-cycle pulse on a non-adjacent jump between valid states.
- step_period  out  PERIOD_WIDTH  clk cycles between the last two valid steps.

Behaviour:
- Reset values: hall_state=3'b111, connected=0, fault=0, hall_count=0, direction=0, step_pulse=0, step_error=0, step_period=0, state=DISCONNECTED. The synchronizers and the debounce candidate also reset to 3'b111.
- Debounce:
  - The candidate register tracks the synchronized value. stable_cnt clears whenever the synchronized value differs from the candidate.
  - The filtered value (hall_state) takes the candidate when stable_cnt reaches DEBOUNCE_CYCLES-1 and candidate != hall_state.
  - Latency from a raw change (setup-met before edge k) to hall_state update is exactly SYNC_STAGES+DEBOUNCE_CYCLES edges. With defaults this is 6.
  - Any raw pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Valid forward sequence: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101. Reverse is the opposite order. 111 and 000 are invalid.
- State machine, evaluated on each cycle the filtered value changes:
  - DISCONNECTED: valid state -> RUNNING (entry is not a step and is not counted); 000 -> FAULT; 111 -> stay.
  - RUNNING: 111 -> DISCONNECTED; 000 -> FAULT; adjacent valid -> step; non-adjacent valid -> step_error pulse with hall_count, direction and step_period unchanged (state stays RUNNING, new value becomes reference).
  - FAULT: latched. Only 111 exits, to DISCONNECTED (motor unplug/replug clears the fault). Valid states are ignored while in FAULT.
- Step in RUNNING:
  - Forward: hall_count+1, direction=1.
  - Reverse: hall_count-1, direction=0.
  - Arithmetic is modulo 2^COUNT_WIDTH (255+1=0, 0-1=255).
  - step_pulse is high for the one cycle after the update edge.
- step_period:
  - The internal cycle counter increments every clk while RUNNING and saturates at 2^PERIOD_WIDTH-1.
  - On a valid step, step_period latches the counter value and the counter restarts at 1.
  - The counter clears to 0 and step_period clears to 0 on any exit from RUNNING.
  - The first step after entering RUNNING latches the time since entry.
- count_load:
  - hall_count takes count_load_value on the next edge in any state.
  - If a step occurs in the same cycle, the load wins and the step's count change is dropped. direction, step_pulse and step_period still update.
- Asserting rst_n low mid-operation returns all outputs to their reset values immediately (asynchronous). The first filtered update after release follows the full debounce latency.

Test Plan:
- Reset, raw 111 held 100 cycles -> hall_state=111, connected=0, fault=0, hall_count=0.
- Raw 000 held 20 cycles -> fault=1 exactly 6 edges after the change. Then raw 101 -> fault stays 1. Then raw 111 -> fault=0, state DISCONNECTED. Then raw 101 -> connected=1 with hall_count still 0.
- From RUNNING at 101, step 100, 110, 010 at 50-cycle spacing -> hall_count=3, direction=1, three step_pulse pulses, step_period=50. Then step back to 110 -> hall_count=2, direction=0.
- Load 8'hFF via count_load, one forward step -> hall_count=0. Load 8'h00, one reverse step -> hall_count=8'hFF. Load coincident with a step, value 8'h0A -> hall_count=8'h0A.
- Glitch: raw 101 -> 110 for 3 cycles then back -> no hall_state change, no step_pulse. Jump 101 -> 010 -> step_error=1 for one cycle, hall_count unchanged.
- Hold a valid state for 70000 cycles, then step -> step_period=16'hFFFF. Assert rst_n mid-debounce -> all outputs at reset values within the same cycle.
